// File: rtl/demux_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants, state encoding and channel-search helpers
//                for the 1:8 demux scan sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    // Index of the lowest set bit of mask (0 when mask is empty).
    function automatic logic [SEL_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] v_idx;
        v_idx = '0;
        // Scan downward so the last hit is the lowest set bit.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                v_idx = SEL_W'(i);
            end
        end
        return v_idx;
    endfunction

    // Returns {wrap, idx}: idx is the next set bit strictly above cur.
    // If none exists the search wraps to the lowest set bit and wrap=1,
    // which also covers a single-channel mask where idx == cur.
    function automatic logic [SEL_W:0] next_ch(input logic [NUM_CH-1:0] mask,
                                               input logic [SEL_W-1:0]  cur);
        logic             v_found;
        logic [SEL_W-1:0] v_hi;
        v_found = 1'b0;
        v_hi    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                v_found = 1'b1;
                v_hi    = SEL_W'(i);
            end
        end
        return v_found ? {1'b0, v_hi} : {1'b1, lowest_ch(mask)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_scan_ctrl_if
//  Description : Control / data bundle between the scan controller and its
//                environment.
//                master : drives start, stop, mode_cont, en_mask, w
//                slave  : drives sel, y, busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_scan_ctrl_if;
    import demux_pkg::*;

    logic              start;
    logic              stop;
    logic              mode_cont;
    logic [NUM_CH-1:0] en_mask;
    logic              w;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] y;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, mode_cont, en_mask, w,
        input  sel, y, busy, done
    );

    modport slave (
        input  start, stop, mode_cont, en_mask, w,
        output sel, y, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/demux_scan_ctrl_demux8_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux8_reg
//  Description : Registered 1:8 demultiplexer. ld loads y <= w << sel,
//                clr loads y <= 0; clr has priority over ld.
//  Ports       : clk, rst (sync, active-high), clr, ld, w, sel -> y
//  Revision    : 1.0 - initial release
// ============================================================================
module demux8_reg
    import demux_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clr,
    input  wire logic              ld,
    input  wire logic              w,
    input  wire logic [SEL_W-1:0]  sel,
    output logic      [NUM_CH-1:0] y
);

    logic [NUM_CH-1:0] r_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
        end else if (clr) begin
            r_y <= '0;
        end else if (ld) begin
            r_y <= NUM_CH'(w) << sel;
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: rtl/demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : demux_scan_ctrl
//  Description : Round-robin scan sequencer for a 1:8 demux. Steps sel
//                through the enabled channels, dwelling DWELL cycles on each,
//                in one-shot or continuous mode.
//  Ports       : clk, rst (sync, active-high)
//                bus (slave): start, stop, mode_cont, en_mask, w in;
//                             sel, y, busy, done out
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_scan_ctrl
    import demux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
)(
    input  wire logic         clk,
    input  wire logic         rst,
    demux_scan_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_sel;
    logic [NUM_CH-1:0] r_mask;
    logic              r_cont;

    logic [SEL_W:0]    w_next;
    logic              w_wrap;
    logic [SEL_W-1:0]  w_next_idx;
    logic              w_dwell_end;
    logic              w_pass_end;
    logic              w_start_ok;
    logic              w_ld;
    logic              w_clr;
    logic [NUM_CH-1:0] w_y;

    assign w_next      = next_ch(r_mask, r_sel);
    assign w_wrap      = w_next[SEL_W];
    assign w_next_idx  = w_next[SEL_W-1:0];
    assign w_dwell_end = (r_cnt == c_DWELL_LAST);
    // A one-shot pass ends when the dwell on the last channel expires.
    assign w_pass_end  = w_dwell_end && w_wrap && !r_cont;
    assign w_start_ok  = bus.start && (bus.en_mask != '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.en_mask != '0) ? c_ST_RUN : c_ST_DONE;
                end
            end
            c_ST_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_pass_end) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.busy = (r_state == c_ST_RUN);
        bus.done = (r_state == c_ST_DONE);
        // Route w only while scanning; every other cycle (and stop) clears y.
        w_ld     = (r_state == c_ST_RUN) && !bus.stop;
        w_clr    = !w_ld;
    end

    // Scan datapath: select, dwell counter, captured mask and mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= '0;
            r_cnt  <= '0;
            r_mask <= '0;
            r_cont <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_ok) begin
                        r_mask <= bus.en_mask;
                        r_cont <= bus.mode_cont;
                        r_sel  <= lowest_ch(bus.en_mask);
                        r_cnt  <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (bus.stop) begin
                        r_sel <= '0;
                        r_cnt <= '0;
                    end else if (w_dwell_end) begin
                        r_cnt <= '0;
                        // Hold sel on the final dwell of a one-shot pass.
                        if (!w_pass_end) begin
                            r_sel <= w_next_idx;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_sel <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    demux8_reg u_demux8_reg (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .ld  (w_ld),
        .w   (bus.w),
        .sel (r_sel),
        .y   (w_y)
    );

    assign bus.sel = r_sel;
    assign bus.y   = w_y;

endmodule
`default_nettype wire

// File: tb/tb_demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_scan_ctrl
//  Description : Scoreboard bench for demux_scan_ctrl. Two instances
//                (DWELL=4 and DWELL=1) receive identical stimulus. A
//                schedule-based model predicts outputs after every edge and
//                queues them; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_scan_ctrl;
    import demux_pkg::*;

    typedef struct packed {
        logic [1:0] mode;   // 0 idle, 1 scanning, 2 done pulse
        int         k;      // scan cycles elapsed
        int         n;      // number of enabled channels
        logic [7:0] msk;
        logic       cont;
        logic [2:0] sel;
        logic [7:0] y;
    } mdl_t;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] y;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic       w = 1'b0;
    logic [7:0] en_mask = 8'h00;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mdl_t m4 = '0;
    mdl_t m1 = '0;
    exp_t q4[$];
    exp_t q1[$];

    demux_scan_ctrl_if b4 ();
    demux_scan_ctrl_if b1 ();

    assign b4.start = start;  assign b4.stop = stop;  assign b4.mode_cont = mode_cont;
    assign b4.en_mask = en_mask;  assign b4.w = w;
    assign b1.start = start;  assign b1.stop = stop;  assign b1.mode_cont = mode_cont;
    assign b1.en_mask = en_mask;  assign b1.w = w;

    demux_scan_ctrl #(.DWELL(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    demux_scan_ctrl #(.DWELL(1), .CNT_W(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    // j-th enabled channel in ascending order.
    function automatic logic [2:0] nth_ch(input logic [7:0] m, input int j);
        int         c;
        logic [2:0] r;
        c = 0;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (c == j) r = 3'(i);
                c++;
            end
        end
        return r;
    endfunction

    // Scan schedule: scan cycle k sits on enabled channel (k / D) mod n.
    function automatic mdl_t mstep(input mdl_t md, input int d);
        mdl_t       r;
        logic [2:0] cur;
        logic [7:0] yn;
        r = md;
        if (rst) begin
            r.mode = 2'd0; r.sel = 3'd0; r.y = 8'h00;
        end else begin
            case (md.mode)
                2'd0: begin
                    r.sel = 3'd0; r.y = 8'h00;
                    if (start) begin
                        if (en_mask != 8'h00) begin
                            r.mode = 2'd1; r.msk = en_mask; r.n = $countones(en_mask);
                            r.cont = mode_cont; r.k = 0; r.sel = nth_ch(en_mask, 0);
                        end else begin
                            r.mode = 2'd2;
                        end
                    end
                end
                2'd1: begin
                    cur = nth_ch(md.msk, (md.k / d) % md.n);
                    yn = 8'h00;
                    yn[cur] = w;
                    if (stop) begin
                        r.mode = 2'd0; r.sel = 3'd0; r.y = 8'h00;
                    end else begin
                        r.k = md.k + 1;
                        r.y = yn;
                        if (!md.cont && r.k == md.n * d) begin
                            r.mode = 2'd2; r.sel = cur;
                        end else begin
                            r.sel = nth_ch(md.msk, (r.k / d) % md.n);
                        end
                    end
                end
                default: begin
                    r.mode = 2'd0; r.sel = 3'd0; r.y = 8'h00;
                end
            endcase
        end
        return r;
    endfunction

    function automatic exp_t toexp(input mdl_t m);
        return {m.sel, m.y, (m.mode == 2'd1), (m.mode == 2'd2)};
    endfunction

    task automatic step();
        @(posedge clk);
        m4 = mstep(m4, 4);
        m1 = mstep(m1, 1);
        q4.push_back(toexp(m4));
        q1.push_back(toexp(m1));
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: every edge's prediction is compared half a cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            cmp("d4_sel",  8'(b4.sel),  8'(e.sel));
            cmp("d4_y",    b4.y,        e.y);
            cmp("d4_busy", 8'(b4.busy), 8'(e.busy));
            cmp("d4_done", 8'(b4.done), 8'(e.done));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("d1_sel",  8'(b1.sel),  8'(e.sel));
            cmp("d1_y",    b1.y,        e.y);
            cmp("d1_busy", 8'(b1.busy), 8'(e.busy));
            cmp("d1_done", 8'(b1.done), 8'(e.done));
        end
    end

    initial begin
        // Reset held two cycles with random inputs
        rst = 1'b1;
        start = 1'($urandom); stop = 1'($urandom); mode_cont = 1'($urandom);
        en_mask = 8'($urandom); w = 1'($urandom);
        run(2);
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        run(2);

        // One-shot over channels 0, 2, 7 with w=1
        en_mask = 8'b1000_0101; mode_cont = 1'b0; w = 1'b1; start = 1'b1;
        step();
        start = 1'b0; en_mask = 8'h00;
        run(16);

        // Continuous on a single channel, then stop
        en_mask = 8'h10; mode_cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        run(20);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run(3);

        // Start with an empty mask: straight to the done pulse
        en_mask = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        run(3);

        // Continuous full mask, w toggling; mask/start changes mid-scan ignored
        en_mask = 8'hFF; mode_cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom);
            if (i == 10) begin en_mask = 8'h01; start = 1'b1; mode_cont = 1'b0; end
            if (i == 12) start = 1'b0;
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        run(2);

        // Start and stop together in idle: start wins
        en_mask = 8'h42; mode_cont = 1'b0; w = 1'b1; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        run(10);

        // Reset in the third cycle of a dwell, then a fresh start
        en_mask = 8'h24; mode_cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        run(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2);
        start = 1'b1;
        step();
        start = 1'b0;
        run(12);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            start     = ($urandom % 6) == 0;
            stop      = ($urandom % 25) == 0;
            mode_cont = 1'($urandom);
            en_mask   = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom);
            w         = 1'($urandom);
            rst       = ($urandom % 150) == 0;
            step();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        run(2);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
